// File: rtl/sdram0_read_arbiter.sv
// rtl/sdram0_read_arbiter.sv - two-requester round-robin arbiter for the f2h_sdram0 burst read port
//
// Two FPGA read masters share one Avalon-MM burst read port. Command slots are
// granted round-robin. Accepted bursts are queued in order in a small tracker
// FIFO, so each returned beat can be routed to the master that issued it.
//
// Ports:
//   clk, rst_n                 clock and synchronous active-low reset
//   m0_* / m1_*                requester command inputs (address, burstcount, read),
//                              waitrequest out, readdata / readdatavalid out
//   s_address, s_burstcount,   command to the SDRAM port
//   s_read
//   s_waitrequest, s_readdata, response from the SDRAM port
//   s_readdatavalid
//   busy                       tracker non-empty or command on the port
//   err_unexpected             sticky: a beat arrived with no burst pending

module sdram0_read_arbiter #(
    parameter int ADDR_W      = 29,
    parameter int DATA_W      = 64,
    parameter int BURST_W     = 8,
    parameter int MAX_PENDING = 4
) (
    input  logic               clk,
    input  logic               rst_n,

    input  logic [ADDR_W-1:0]  m0_address,
    input  logic [BURST_W-1:0] m0_burstcount,
    input  logic               m0_read,
    output logic               m0_waitrequest,
    output logic [DATA_W-1:0]  m0_readdata,
    output logic               m0_readdatavalid,

    input  logic [ADDR_W-1:0]  m1_address,
    input  logic [BURST_W-1:0] m1_burstcount,
    input  logic               m1_read,
    output logic               m1_waitrequest,
    output logic [DATA_W-1:0]  m1_readdata,
    output logic               m1_readdatavalid,

    output logic [ADDR_W-1:0]  s_address,
    output logic [BURST_W-1:0] s_burstcount,
    output logic               s_read,
    input  logic               s_waitrequest,
    input  logic [DATA_W-1:0]  s_readdata,
    input  logic               s_readdatavalid,

    output logic               busy,
    output logic               err_unexpected
);

    localparam int PTR_W = (MAX_PENDING > 1) ? $clog2(MAX_PENDING) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_PENDING);

    // Arbitration state
    logic               r_rr_ptr;
    logic               r_lock_valid;
    logic               r_lock_id;

    // In-order tracker of accepted bursts
    logic               r_fifo_id    [MAX_PENDING];
    logic [BURST_W-1:0] r_fifo_beats [MAX_PENDING];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic [BURST_W-1:0] r_beat_cnt;
    logic               r_err;

    logic               w_grant_valid;
    logic               w_grant_id;
    logic               w_accept;
    logic               w_stall;
    logic [BURST_W-1:0] w_push_beats;
    logic               w_not_empty;
    logic               w_head_id;
    logic [BURST_W-1:0] w_head_beats;
    logic               w_beat;
    logic               w_last_beat;
    logic               w_pop;

    // Grant selection. A stalled command keeps its grant regardless of the
    // full check: it was granted while not full and count cannot grow while
    // the lock is held.
    always_comb begin
        w_grant_valid = 1'b0;
        w_grant_id    = 1'b0;
        if (r_lock_valid) begin
            w_grant_valid = 1'b1;
            w_grant_id    = r_lock_id;
        end else if (r_count < FULL_CNT) begin
            if (m0_read && m1_read) begin
                w_grant_valid = 1'b1;
                w_grant_id    = r_rr_ptr;
            end else if (m0_read) begin
                w_grant_valid = 1'b1;
                w_grant_id    = 1'b0;
            end else if (m1_read) begin
                w_grant_valid = 1'b1;
                w_grant_id    = 1'b1;
            end
        end
    end

    // Zero-latency command path
    assign s_read       = w_grant_valid && (w_grant_id ? m1_read : m0_read);
    assign s_address    = w_grant_id ? m1_address    : m0_address;
    assign s_burstcount = w_grant_id ? m1_burstcount : m0_burstcount;

    assign w_accept = s_read && !s_waitrequest;
    assign w_stall  = s_read &&  s_waitrequest;

    assign m0_waitrequest = !(w_accept && !w_grant_id);
    assign m1_waitrequest = !(w_accept &&  w_grant_id);

    // A zero burstcount still returns one beat on the port, so track it as one.
    assign w_push_beats = (s_burstcount == '0) ? BURST_W'(1) : s_burstcount;

    // Zero-latency response routing from the head of the tracker
    assign w_not_empty  = (r_count != '0);
    assign w_head_id    = r_fifo_id[r_rd_ptr];
    assign w_head_beats = r_fifo_beats[r_rd_ptr];
    assign w_beat       = s_readdatavalid && w_not_empty;
    assign w_last_beat  = (r_beat_cnt == (w_head_beats - BURST_W'(1)));
    assign w_pop        = w_beat && w_last_beat;

    assign m0_readdata      = s_readdata;
    assign m1_readdata      = s_readdata;
    assign m0_readdatavalid = w_beat && !w_head_id;
    assign m1_readdatavalid = w_beat &&  w_head_id;

    assign busy           = w_not_empty || s_read;
    assign err_unexpected = r_err;

    // Arbitration registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rr_ptr     <= 1'b0;
            r_lock_valid <= 1'b0;
            r_lock_id    <= 1'b0;
        end else if (w_accept) begin
            r_rr_ptr     <= ~w_grant_id;
            r_lock_valid <= 1'b0;
        end else if (w_stall) begin
            r_lock_valid <= 1'b1;
            r_lock_id    <= w_grant_id;
        end
    end

    // Tracker storage
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < MAX_PENDING; i++) begin
                r_fifo_id[i]    <= 1'b0;
                r_fifo_beats[i] <= '0;
            end
        end else if (w_accept) begin
            r_fifo_id[r_wr_ptr]    <= w_grant_id;
            r_fifo_beats[r_wr_ptr] <= w_push_beats;
        end
    end

    // Tracker pointers, pending count, beat counter and error flag.
    // Push is impossible while full, so count never overflows; a
    // simultaneous push and pop leaves it unchanged.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_beat_cnt <= '0;
            r_err      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr   <= r_rd_ptr + PTR_W'(1);
                r_beat_cnt <= '0;
            end else if (w_beat) begin
                r_beat_cnt <= r_beat_cnt + BURST_W'(1);
            end
            case ({w_accept, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (s_readdatavalid && !w_not_empty) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sdram0_read_arbiter.sv
// tb/tb_sdram0_read_arbiter.sv - directed self-checking bench for sdram0_read_arbiter

module tb_sdram0_read_arbiter;

    localparam int ADDR_W = 29;
    localparam int DATA_W = 64;
    localparam int BURST_W = 8;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [ADDR_W-1:0]  m0_address, m1_address;
    logic [BURST_W-1:0] m0_burstcount, m1_burstcount;
    logic               m0_read, m1_read;
    logic               m0_waitrequest, m1_waitrequest;
    logic [DATA_W-1:0]  m0_readdata, m1_readdata;
    logic               m0_readdatavalid, m1_readdatavalid;
    logic [ADDR_W-1:0]  s_address;
    logic [BURST_W-1:0] s_burstcount;
    logic               s_read;
    logic               s_waitrequest;
    logic [DATA_W-1:0]  s_readdata;
    logic               s_readdatavalid;
    logic               busy;
    logic               err_unexpected;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    sdram0_read_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_W(BURST_W), .MAX_PENDING(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_address(m0_address), .m0_burstcount(m0_burstcount), .m0_read(m0_read),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
        .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_burstcount(m1_burstcount), .m1_read(m1_read),
        .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
        .m1_readdatavalid(m1_readdatavalid),
        .s_address(s_address), .s_burstcount(s_burstcount), .s_read(s_read),
        .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
        .s_readdatavalid(s_readdatavalid),
        .busy(busy), .err_unexpected(err_unexpected)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 ns after the rising edge; outputs are checked at the falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic do_reset();
        tick();
        rst_n = 1'b0;
        m0_read = 1'b0; m1_read = 1'b0;
        s_readdatavalid = 1'b0; s_waitrequest = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_s_read"}, 64'(s_read), 64'd0);
        check({tag, "_m0_wr"}, 64'(m0_waitrequest), 64'd1);
        check({tag, "_m1_wr"}, 64'(m1_waitrequest), 64'd1);
        check({tag, "_m0_rdv"}, 64'(m0_readdatavalid), 64'd0);
        check({tag, "_m1_rdv"}, 64'(m1_readdatavalid), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        m0_address = '0; m1_address = '0;
        m0_burstcount = '0; m1_burstcount = '0;
        m0_read = 1'b0; m1_read = 1'b0;
        s_waitrequest = 1'b0; s_readdata = '0; s_readdatavalid = 1'b0;

        // Reset state
        tick(); tick();
        settle();
        check_idle("reset");
        check("reset_err", 64'(err_unexpected), 64'd0);
        tick();
        rst_n = 1'b1;

        // Single m0 burst of 4 at 0x100
        tick();
        m0_read = 1'b1; m0_address = 29'h100; m0_burstcount = 8'd4;
        settle();
        check("t1_s_read", 64'(s_read), 64'd1);
        check("t1_s_addr", 64'(s_address), 64'h100);
        check("t1_s_burst", 64'(s_burstcount), 64'd4);
        check("t1_m0_wr", 64'(m0_waitrequest), 64'd0);
        check("t1_m1_wr", 64'(m1_waitrequest), 64'd1);
        tick();
        m0_read = 1'b0;
        settle();
        check("t1_m0_wr_after", 64'(m0_waitrequest), 64'd1);
        check("t1_busy", 64'(busy), 64'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            s_readdatavalid = 1'b1; s_readdata = 64'hA0 + 64'(i);
            settle();
            check("t1_m0_rdv", 64'(m0_readdatavalid), 64'd1);
            check("t1_m1_rdv", 64'(m1_readdatavalid), 64'd0);
            check("t1_m0_data", m0_readdata, 64'hA0 + 64'(i));
        end
        tick();
        s_readdatavalid = 1'b0;
        settle();
        check("t1_busy_done", 64'(busy), 64'd0);

        // Contention right after reset: m0 first, then m1
        do_reset();
        tick();
        m0_read = 1'b1; m0_address = 29'h10; m0_burstcount = 8'd2;
        m1_read = 1'b1; m1_address = 29'h20; m1_burstcount = 8'd3;
        settle();
        check("t2_c0_addr", 64'(s_address), 64'h10);
        check("t2_c0_m0_wr", 64'(m0_waitrequest), 64'd0);
        check("t2_c0_m1_wr", 64'(m1_waitrequest), 64'd1);
        tick();
        m0_read = 1'b0;
        settle();
        check("t2_c1_addr", 64'(s_address), 64'h20);
        check("t2_c1_burst", 64'(s_burstcount), 64'd3);
        check("t2_c1_m1_wr", 64'(m1_waitrequest), 64'd0);
        tick();
        m1_read = 1'b0;
        for (int i = 0; i < 5; i++) begin
            s_readdatavalid = 1'b1;
            settle();
            check("t2_m0_rdv", 64'(m0_readdatavalid), (i < 2) ? 64'd1 : 64'd0);
            check("t2_m1_rdv", 64'(m1_readdatavalid), (i < 2) ? 64'd0 : 64'd1);
            tick();
        end
        s_readdatavalid = 1'b0;

        // Stall lock: m0 held by waitrequest for 3 cycles, m1 joins in cycle 1
        m0_read = 1'b1; m0_address = 29'h30; m0_burstcount = 8'd1;
        s_waitrequest = 1'b1;
        settle();
        check("t3_c0_addr", 64'(s_address), 64'h30);
        check("t3_c0_m0_wr", 64'(m0_waitrequest), 64'd1);
        tick();
        m1_read = 1'b1; m1_address = 29'h40; m1_burstcount = 8'd1;
        for (int i = 1; i < 3; i++) begin
            settle();
            check("t3_lock_addr", 64'(s_address), 64'h30);
            check("t3_lock_m1_wr", 64'(m1_waitrequest), 64'd1);
            check("t3_lock_m0_wr", 64'(m0_waitrequest), 64'd1);
            tick();
        end
        s_waitrequest = 1'b0;
        settle();
        check("t3_acc_addr", 64'(s_address), 64'h30);
        check("t3_acc_m0_wr", 64'(m0_waitrequest), 64'd0);
        check("t3_acc_m1_wr", 64'(m1_waitrequest), 64'd1);
        tick();
        m0_read = 1'b0;
        settle();
        check("t3_m1_addr", 64'(s_address), 64'h40);
        check("t3_m1_wr", 64'(m1_waitrequest), 64'd0);
        tick();
        m1_read = 1'b0;
        s_readdatavalid = 1'b1;
        settle();
        check("t3_beat0_m0", 64'(m0_readdatavalid), 64'd1);
        tick();
        settle();
        check("t3_beat1_m1", 64'(m1_readdatavalid), 64'd1);
        check("t3_beat1_m0", 64'(m0_readdatavalid), 64'd0);
        tick();
        s_readdatavalid = 1'b0;

        // Full tracker: four len-2 bursts, then a zero-length 5th waits for a pop
        m0_read = 1'b1; m0_address = 29'h50; m0_burstcount = 8'd2;
        for (int i = 0; i < 4; i++) begin
            settle();
            check("t4_fill_m0_wr", 64'(m0_waitrequest), 64'd0);
            tick();
        end
        m0_burstcount = 8'd0;
        settle();
        check("t4_full_s_read", 64'(s_read), 64'd0);
        check("t4_full_m0_wr", 64'(m0_waitrequest), 64'd1);
        check("t4_full_busy", 64'(busy), 64'd1);
        tick();
        s_readdatavalid = 1'b1;
        settle();
        check("t4_b1_rdv", 64'(m0_readdatavalid), 64'd1);
        check("t4_b1_s_read", 64'(s_read), 64'd0);
        tick();
        settle();
        check("t4_b2_s_read", 64'(s_read), 64'd0);
        check("t4_b2_m0_wr", 64'(m0_waitrequest), 64'd1);
        tick();
        s_readdatavalid = 1'b0;
        settle();
        check("t4_freed_s_read", 64'(s_read), 64'd1);
        check("t4_freed_burst", 64'(s_burstcount), 64'd0);
        check("t4_freed_m0_wr", 64'(m0_waitrequest), 64'd0);
        tick();
        m0_read = 1'b0;
        for (int i = 0; i < 7; i++) begin
            s_readdatavalid = 1'b1;
            settle();
            check("t4_drain_rdv", 64'(m0_readdatavalid), 64'd1);
            tick();
        end
        s_readdatavalid = 1'b0;
        settle();
        check("t4_drained_busy", 64'(busy), 64'd0);
        check("t4_drained_err", 64'(err_unexpected), 64'd0);

        // Unexpected beat with empty tracker
        tick();
        s_readdatavalid = 1'b1;
        settle();
        check("t5_m0_rdv", 64'(m0_readdatavalid), 64'd0);
        check("t5_m1_rdv", 64'(m1_readdatavalid), 64'd0);
        tick();
        s_readdatavalid = 1'b0;
        settle();
        check("t5_err_set", 64'(err_unexpected), 64'd1);
        tick(); tick(); tick();
        settle();
        check("t5_err_sticky", 64'(err_unexpected), 64'd1);

        // Reset during beat 2 of a len-4 burst
        do_reset();
        settle();
        check("t6_err_cleared", 64'(err_unexpected), 64'd0);
        tick();
        m0_read = 1'b1; m0_address = 29'h200; m0_burstcount = 8'd4;
        settle();
        check("t6_acc_m0_wr", 64'(m0_waitrequest), 64'd0);
        tick();
        m0_read = 1'b0;
        s_readdatavalid = 1'b1;
        settle();
        check("t6_beat1_rdv", 64'(m0_readdatavalid), 64'd1);
        tick();
        rst_n = 1'b0;
        settle();
        check("t6_beat2_rdv", 64'(m0_readdatavalid), 64'd1);
        tick();
        rst_n = 1'b1;
        settle();
        check_idle("t6_after_rst");
        check("t6_after_rst_err", 64'(err_unexpected), 64'd0);
        tick();
        settle();
        check("t6_beat4_rdv", 64'(m0_readdatavalid), 64'd0);
        check("t6_beat4_err", 64'(err_unexpected), 64'd1);
        tick();
        s_readdatavalid = 1'b0;
        settle();
        check("t6_err_hold", 64'(err_unexpected), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/sdram0_read_arbiter.md
# sdram0_read_arbiter

Two-requester arbiter for the single FPGA-to-HPS SDRAM read port (f2h_sdram0, Avalon-MM burst read, 64-bit data). It lets two FPGA read masters share the port in the FPGA_CLK1_50 domain: a test reader and a future DMA/stream reader. It grants command slots round-robin and tracks outstanding bursts in order. Each returned beat is routed to the master that issued the burst.

## Interface
Parameters:
- ADDR_W, 29, word address width of f2h_sdram0
- DATA_W, 64, read data width
- BURST_W, 8, burstcount width
- MAX_PENDING, 4, maximum accepted-but-incomplete bursts; power of two, ≥2

Ports:
- clk  in  1  FPGA_CLK1_50; all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- m0_address / m1_address  in  ADDR_W  requester word address
- m0_burstcount / m1_burstcount  in  BURST_W  requester burst length in beats
- m0_read / m1_read  in  1  requester read command
- m0_waitrequest / m1_waitrequest  out  1  high = command not accepted this cycle
- m0_readdata / m1_readdata  out  DATA_W  s_readdata broadcast to both
- m0_readdatavalid / m1_readdatavalid  out  1  beat belongs to this requester
- s_address  out  ADDR_W  to f2h_sdram0 address
- s_burstcount  out  BURST_W  to f2h_sdram0 burstcount
- s_read  out  1  to f2h_sdram0 read
- s_waitrequest  in  1  from f2h_sdram0
- s_readdata  in  DATA_W  from f2h_sdram0
- s_readdatavalid  in  1  from f2h_sdram0
- busy  out  1  pending count ≠ 0 or s_read high
- err_unexpected  out  1  sticky: beat arrived with no pending burst

## Operation
- Registered state:
  - rr_ptr (1 b): preferred requester.
  - lock_valid, lock_id: command stalled by s_waitrequest.
  - Tracker FIFO of {id, beats}, MAX_PENDING deep, with a pending count.
  - beat_cnt for the head burst.
  - err_unexpected.
- Grant selection (combinational):
  - If lock_valid, grant = lock_id.
  - Otherwise, if count < MAX_PENDING, grant the requester with read high. When both are high, grant rr_ptr.
  - Otherwise, no grant.
- Command forwarding:
  - s_read = granted requester's read.
  - s_address and s_burstcount are muxed from the granted requester.
  - A burstcount of 0 is forwarded and tracked as 1.
- Acceptance = s_read && !s_waitrequest. On acceptance:
  - Granted mX_waitrequest is low that cycle; all other waitrequests are high.
  - Push {grant, beats} into the tracker.
  - rr_ptr <= ~grant.
  - lock_valid <= 0.
- Stall: s_read && s_waitrequest sets lock_valid <= 1 and lock_id <= grant. The grant cannot change until acceptance, even if the other requester asserts read.
- Response path:
  - When s_readdatavalid is high and the tracker is non-empty, assert m{head.id}_readdatavalid and increment beat_cnt.
  - When beat_cnt reaches head.beats-1, pop the head and clear beat_cnt.
- Unexpected beat: s_readdatavalid with an empty tracker is dropped (no mX_readdatavalid) and sets err_unexpected. The flag clears only on reset.
- Simultaneous push and pop: both occur, and count is unchanged.

## Timing
- Command path has zero latency: s_read/s_address follow mX_* in the same cycle.
- Response routing has zero latency: mX_readdatavalid is asserted in the same cycle as s_readdatavalid.
- Full is evaluated on the registered count. A slot freed by a pop is usable the next cycle.
- Back-to-back acceptance is allowed every cycle while not full. Alternation is guaranteed under contention.
- Reset values: s_read 0, mX_waitrequest 1, mX_readdatavalid 0, busy 0, err_unexpected 0. Also rr_ptr 0, lock cleared, tracker empty, beat_cnt 0.
- Reset mid-burst discards all tracking. Beats arriving after reset release set err_unexpected.

## Test plan
- m0 reads burst 4 at 0x100 with s_waitrequest low → s_read and s_address=0x100 in the same cycle, m0_waitrequest low 1 cycle. Four beats go to m0_readdatavalid; m1_readdatavalid stays 0.
- Both request (m0 0x10 len 2, m1 0x20 len 3) right after reset → m0 accepted cycle 0, m1 cycle 1. Beats 1–2 go to m0 and beats 3–5 to m1.
- m0 granted and s_waitrequest held high 3 cycles; m1 asserts read in cycle 1 → s_address stays m0's, m1_waitrequest high throughout. m1 accepted the cycle after m0.
- MAX_PENDING=4: four len-2 bursts accepted with no data returned → 5th request sees s_read 0 and waitrequest 1. It is accepted 1 cycle after the 2nd beat of the first burst.
- s_readdatavalid pulse with empty tracker → no mX_readdatavalid, err_unexpected=1 and stays 1 until rst_n low.
- rst_n low for 1 cycle during beat 2 of a len-4 burst → all outputs at reset values next cycle. Remaining 2 beats are dropped and set err_unexpected.
